// File: rtl/coso_pkg.sv
// Shared types and constants for the coherent-sampling bit collector.
// Optional repetition health test is enabled with the COSO_HEALTH_EN macro.
package coso_pkg;

    // Packing FSM: FILL while gathering bits, XFER for the single hand-off cycle.
    typedef enum logic {
        FILL = 1'b0,
        XFER = 1'b1
    } coso_state_e;

    // A count of all ones means the run-length counter saturated (not locked).
    localparam logic [7:0] CNT_SAT         = 8'hFF;
    localparam logic [7:0] CNT_MIN_DEFAULT = 8'd4;

    // Increment that sticks at CNT_SAT instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CNT_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/coso_rep_test.sv
// Repetition health test: counts consecutive equal sample bits and raises a
// sticky failure once the run reaches REP_LIMIT. Used only with COSO_HEALTH_EN.
module coso_rep_test #(
    parameter int REP_LIMIT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_valid,
    input  logic sample_bit,
    output logic fail
);

    localparam int RUN_W = $clog2(REP_LIMIT + 1);
    localparam logic [RUN_W-1:0] LIMIT_C = RUN_W'(REP_LIMIT);

    logic             last_q, last_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             fail_q, fail_d;

    // Run-length tracking of the accepted-sample bit; run saturates at the limit.
    always_comb begin
        last_d = last_q;
        run_d  = run_q;
        fail_d = fail_q;
        if (sample_valid) begin
            last_d = sample_bit;
            if ((run_q != '0) && (sample_bit == last_q)) begin
                if (run_q != LIMIT_C) begin
                    run_d = run_q + 1'b1;
                end
            end else begin
                run_d = RUN_W'(1);
            end
            if (run_d == LIMIT_C) begin
                fail_d = 1'b1;
            end
        end
    end

    // State registers; failure flag is cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
            run_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            last_q <= last_d;
            run_q  <= run_d;
            fail_q <= fail_d;
        end
    end

    assign fail = fail_q;

endmodule

// File: rtl/coso_bit_collector.sv
// Consumer end of the coherent-sampling count stream: range-checks COUNT
// samples, packs their LSBs into DATA_W-bit words and offers them on a
// valid/ready port. Define COSO_HEALTH_EN to add the repetition health test.
//
// Handshake: DOUT_VALID high means DOUT holds an unconsumed word; the word is
// transferred on any clock edge where DOUT_VALID & DOUT_READY, and DOUT and
// DOUT_VALID hold steady while DOUT_VALID & ~DOUT_READY.
module coso_bit_collector
    import coso_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         BPS       = 1,
    parameter logic [7:0] CNT_MIN   = CNT_MIN_DEFAULT,
    parameter int         REP_LIMIT = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [7:0]        COUNT,
    input  logic              COUNT_EN,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic [7:0]        OVERRUN,
    output logic [7:0]        REJECTS,
    output logic              HEALTH_FAIL,
    output coso_state_e       STATE_DBG
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] BPS_C  = CNT_W'(BPS);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DATA_W);

    // Reject impossible configurations at elaboration time.
    if ((BPS < 1) || (BPS > 4) || (DATA_W <= BPS) || ((DATA_W % BPS) != 0)) begin : g_cfg_err
        $error("coso_bit_collector: DATA_W must be a multiple of BPS, BPS in 1..4");
    end
    if (REP_LIMIT < 2) begin : g_rep_err
        $error("coso_bit_collector: REP_LIMIT must be at least 2");
    end

    coso_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic [7:0]        overrun_q, overrun_d;
    logic [7:0]        rejects_q, rejects_d;

    logic sample_ok;
    logic accept;
    logic health_fail;

    // Locked counts only: below CNT_MIN or saturated are unusable.
    assign sample_ok = (COUNT >= CNT_MIN) && (COUNT != CNT_SAT);
    assign accept    = EN & COUNT_EN & sample_ok;

`ifdef COSO_HEALTH_EN
    coso_rep_test #(
        .REP_LIMIT(REP_LIMIT)
    ) u_rep_test (
        .clk         (CLK),
        .rst         (RST),
        .sample_valid(accept),
        .sample_bit  (COUNT[0]),
        .fail        (health_fail)
    );
`else
    assign health_fail = 1'b0;
`endif

    // Next-state: word hand-off, holding-register handshake, sample intake.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        rejects_d    = rejects_q;

        if (dout_valid_q && DOUT_READY) begin
            dout_valid_d = 1'b0;
        end

        // A full word sits in shift_q for exactly this cycle.
        if (state_q == XFER) begin
            state_d   = FILL;
            bit_cnt_d = '0;
            if (health_fail) begin
                // Untrusted source: discard silently.
            end else if (!dout_valid_q || DOUT_READY) begin
                dout_d       = shift_q;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = sat_inc(overrun_q);
            end
        end

        // Intake runs alongside XFER so the next word's first bit is not lost.
        if (!EN) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (COUNT_EN) begin
            if (sample_ok) begin
                shift_d   = {shift_q[DATA_W-BPS-1:0], COUNT[BPS-1:0]};
                bit_cnt_d = bit_cnt_d + BPS_C;
                if (bit_cnt_d == FULL_C) begin
                    state_d = XFER;
                end
            end else begin
                rejects_d = sat_inc(rejects_q);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= FILL;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 8'h00;
            rejects_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            rejects_q    <= rejects_d;
        end
    end

    assign DOUT        = dout_q;
    assign DOUT_VALID  = dout_valid_q;
    assign OVERRUN     = overrun_q;
    assign REJECTS     = rejects_q;
    assign HEALTH_FAIL = health_fail;
    assign STATE_DBG   = state_q;

endmodule
